// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared types and constants for the instruction memory responder
package msrv32_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, RESP, ERR1, ERR2} imem_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int WAIT_MAX = 15;

endpackage

// File: rtl/msrv32_imem_responder_if.sv
// rtl/msrv32_imem_responder_if.sv - fetch, response and preload signals between PC mux and instruction memory
interface msrv32_imem_responder_if;

  logic [31:0] iaddr_in;
  logic        ifetch_req_in;
  logic        ahb_ready_out;
  logic [31:0] instr_out;
  logic        instr_valid_out;
  logic        resp_err_out;
  logic        load_en_in;
  logic [31:0] load_addr_in;
  logic [31:0] load_data_in;

  modport master (
    output iaddr_in, ifetch_req_in, load_en_in, load_addr_in, load_data_in,
    input  ahb_ready_out, instr_out, instr_valid_out, resp_err_out
  );

  modport slave (
    input  iaddr_in, ifetch_req_in, load_en_in, load_addr_in, load_data_in,
    output ahb_ready_out, instr_out, instr_valid_out, resp_err_out
  );

endinterface

// File: rtl/msrv32_imem_array.sv
// rtl/msrv32_imem_array.sv - instruction word storage, one synchronous write port and one asynchronous read port
module msrv32_imem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  // Contents are deliberately never reset so a boot image survives a core reset.
  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/msrv32_imem_responder.sv
// rtl/msrv32_imem_responder.sv - instruction fetch responder with wait states, error response and preload port
module msrv32_imem_responder
  import msrv32_pkg::*;
#(
  parameter int          MEM_DEPTH   = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  msrv32_imem_responder_if.slave   bus
);

  localparam int          AW  = $clog2(MEM_DEPTH);
  localparam logic [3:0]  WS4 = 4'(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX) begin : g_bad_wait
    $error("msrv32_imem_responder: WAIT_STATES must be in 0..15");
  end
  if ((1 << AW) != MEM_DEPTH) begin : g_bad_depth
    $error("msrv32_imem_responder: MEM_DEPTH must be a power of 2");
  end

  imem_state_e   r_state;
  logic          r_ready;
  logic          r_valid;
  logic          r_err;
  logic [31:0]   r_instr;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;

  logic [31:0]   w_off;
  logic          w_bad;
  logic [AW-1:0] w_idx;
  logic          w_accept;
  logic [31:0]   w_ld_off;
  logic          w_ld_we;
  logic [AW-1:0] w_ld_idx;
  logic [AW-1:0] w_rd_idx;
  logic [31:0]   w_mem_rdata;
  logic [31:0]   w_rd_data;
  logic          w_unused_ld;

  // BASE_ADDR is aligned to the window size, so any high offset bit means out of range.
  assign w_off    = bus.iaddr_in - BASE_ADDR;
  assign w_bad    = (|w_off[1:0]) | (|w_off[31:AW+2]);
  assign w_idx    = w_off[AW+1:2];
  assign w_accept = bus.ifetch_req_in & r_ready;

  assign w_ld_off    = bus.load_addr_in - BASE_ADDR;
  assign w_ld_we     = bus.load_en_in & ~(|w_ld_off[31:AW+2]);
  assign w_ld_idx    = w_ld_off[AW+1:2];
  assign w_unused_ld = &{1'b0, w_ld_off[1:0]};

  // Only the WAIT->RESP transition reads the captured address; all other reads are same-edge.
  assign w_rd_idx  = (r_state == WAIT) ? r_idx : w_idx;
  assign w_rd_data = (w_ld_we && (w_ld_idx == w_rd_idx)) ? bus.load_data_in : w_mem_rdata;

  msrv32_imem_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk   (clk_in),
    .i_we    (w_ld_we),
    .i_waddr (w_ld_idx),
    .i_wdata (bus.load_data_in),
    .i_raddr (w_rd_idx),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_instr <= NOP;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_valid <= 1'b1;
            r_instr <= w_rd_data;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ERR1: begin
          r_state <= ERR2;
          r_ready <= 1'b1;
          r_err   <= 1'b1;
        end
        default: begin
          // IDLE, RESP and ERR2 all accept a new address phase.
          if (w_accept) begin
            r_idx <= w_idx;
            if (w_bad) begin
              r_state <= ERR1;
              r_ready <= 1'b0;
              r_err   <= 1'b1;
              r_instr <= NOP;
            end else if (WAIT_STATES == 0) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_valid <= 1'b1;
              r_instr <= w_rd_data;
            end else begin
              r_state <= WAIT;
              r_ready <= 1'b0;
              r_cnt   <= WS4;
            end
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.ahb_ready_out   = r_ready;
  assign bus.instr_valid_out = r_valid;
  assign bus.resp_err_out    = r_err;
  assign bus.instr_out       = r_instr;

endmodule

// File: tb/tb_msrv32_imem_responder.sv
// tb/tb_msrv32_imem_responder.sv - self-checking bench for the instruction memory responder
module tb_msrv32_imem_responder;

  localparam logic [31:0] NOPV = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   miss = 0;
  logic [31:0] mem_m [1024];
  logic [31:0] a_w [4];

  msrv32_imem_responder_if if0 ();
  msrv32_imem_responder_if if2 ();

  msrv32_imem_responder #(.MEM_DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk_in (clk), .rst_in (rst), .bus (if0)
  );
  msrv32_imem_responder #(.MEM_DEPTH(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut2 (
    .clk_in (clk), .rst_in (rst), .bus (if2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic req, input logic [31:0] a);
    if (sel != 0) begin
      if2.ifetch_req_in = req;
      if2.iaddr_in      = a;
    end else begin
      if0.ifetch_req_in = req;
      if0.iaddr_in      = a;
    end
  endtask

  task automatic load(input logic en, input logic [31:0] a, input logic [31:0] d);
    if0.load_en_in = en; if0.load_addr_in = a; if0.load_data_in = d;
    if2.load_en_in = en; if2.load_addr_in = a; if2.load_data_in = d;
  endtask

  function automatic logic [34:0] obs(input int sel);
    if (sel != 0) return {if2.ahb_ready_out, if2.instr_valid_out, if2.resp_err_out, if2.instr_out};
    return {if0.ahb_ready_out, if0.instr_valid_out, if0.resp_err_out, if0.instr_out};
  endfunction

  task automatic test_reset();
    logic [34:0] got;
    rst = 1'b1;
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      got = obs(s);
      vec++;
      if (got !== {3'b100, NOPV}) begin
        miss++; $display("FAIL reset dut%0d got %h exp %h", s * 2, got, {3'b100, NOPV});
      end
    end
    rst = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 1024; i++) begin
      mem_m[i] = $urandom;
      load(1'b1, 32'(i * 4), mem_m[i]);
      tick();
    end
    load(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [34:0] got;
    for (int k = 0; k < 4; k++) begin
      a_w[k] = $urandom;
      mem_m[k] = a_w[k];
      load(1'b1, 32'(k * 4), a_w[k]);
      tick();
    end
    load(1'b1, 32'h0000_1000, ~a_w[0]);
    tick();
    load(1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 32'(k * 4));
      tick();
      got = obs(0);
      vec++;
      if (got !== {3'b110, a_w[k]}) begin
        miss++; $display("FAIL b2b_fetch%0d got %h exp %h", k, got, {3'b110, a_w[k]});
      end
    end
    drive(0, 1'b0, 32'h0);
    tick();
    got = obs(0);
    vec++;
    if (got !== {3'b100, a_w[3]}) begin
      miss++; $display("FAIL b2b_hold got %h exp %h", got, {3'b100, a_w[3]});
    end
  endtask

  task automatic test_wait();
    logic [34:0] got;
    drive(1, 1'b1, 32'h10);
    tick();
    got = obs(1); vec++;
    if (got !== {3'b000, NOPV}) begin
      miss++; $display("FAIL wait_c1 got %h exp %h", got, {3'b000, NOPV});
    end
    drive(1, 1'b1, 32'h14);
    tick();
    got = obs(1); vec++;
    if (got !== {3'b000, NOPV}) begin
      miss++; $display("FAIL wait_c2 got %h exp %h", got, {3'b000, NOPV});
    end
    drive(1, 1'b0, 32'h0);
    tick();
    got = obs(1); vec++;
    if (got !== {3'b110, mem_m[4]}) begin
      miss++; $display("FAIL wait_resp got %h exp %h", got, {3'b110, mem_m[4]});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      got = obs(1); vec++;
      if (got !== {3'b100, mem_m[4]}) begin
        miss++; $display("FAIL wait_after%0d got %h exp %h", k, got, {3'b100, mem_m[4]});
      end
    end
  endtask

  task automatic test_error();
    logic [34:0] got;
    drive(0, 1'b1, 32'h6);
    tick();
    got = obs(0); vec++;
    if (got !== {3'b001, NOPV}) begin
      miss++; $display("FAIL err_mis_e1 got %h exp %h", got, {3'b001, NOPV});
    end
    drive(0, 1'b1, 32'h8);
    tick();
    got = obs(0); vec++;
    if (got !== {3'b101, NOPV}) begin
      miss++; $display("FAIL err_mis_e2 got %h exp %h", got, {3'b101, NOPV});
    end
    drive(0, 1'b1, 32'h1000);
    tick();
    got = obs(0); vec++;
    if (got !== {3'b001, NOPV}) begin
      miss++; $display("FAIL err_oor_e1 got %h exp %h", got, {3'b001, NOPV});
    end
    drive(0, 1'b0, 32'h0);
    tick();
    got = obs(0); vec++;
    if (got !== {3'b101, NOPV}) begin
      miss++; $display("FAIL err_oor_e2 got %h exp %h", got, {3'b101, NOPV});
    end
    drive(0, 1'b1, 32'hFFC);
    tick();
    got = obs(0); vec++;
    if (got !== {3'b110, mem_m[1023]}) begin
      miss++; $display("FAIL err_then_last got %h exp %h", got, {3'b110, mem_m[1023]});
    end
    drive(0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [34:0] got;
    drive(1, 1'b1, 32'h8);
    tick();
    got = obs(1); vec++;
    if (got !== {3'b000, mem_m[4]}) begin
      miss++; $display("FAIL rstmid_wait got %h exp %h", got, {3'b000, mem_m[4]});
    end
    drive(1, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = obs(1); vec++;
    if (got !== {3'b100, NOPV}) begin
      miss++; $display("FAIL rstmid_reset got %h exp %h", got, {3'b100, NOPV});
    end
    tick();
    got = obs(1); vec++;
    if (got !== {3'b100, NOPV}) begin
      miss++; $display("FAIL rstmid_nopulse got %h exp %h", got, {3'b100, NOPV});
    end
    drive(1, 1'b1, 32'hC);
    tick();
    drive(1, 1'b0, 32'h0);
    tick();
    tick();
    got = obs(1); vec++;
    if (got !== {3'b110, mem_m[3]}) begin
      miss++; $display("FAIL rstmid_refetch got %h exp %h", got, {3'b110, mem_m[3]});
    end
  endtask

  task automatic test_write_first();
    logic [34:0] got;
    logic [31:0] x;
    load(1'b1, 32'h20, 32'hDEAD_BEEF);
    drive(0, 1'b1, 32'h20);
    tick();
    mem_m[8] = 32'hDEAD_BEEF;
    load(1'b0, 32'h0, 32'h0);
    got = obs(0); vec++;
    if (got !== {3'b110, 32'hDEAD_BEEF}) begin
      miss++; $display("FAIL wf_same_edge got %h exp %h", got, {3'b110, 32'hDEAD_BEEF});
    end
    tick();
    got = obs(0); vec++;
    if (got !== {3'b110, mem_m[8]}) begin
      miss++; $display("FAIL wf_stored got %h exp %h", got, {3'b110, mem_m[8]});
    end
    drive(0, 1'b0, 32'h0);
    x = $urandom;
    drive(1, 1'b1, 32'h24);
    tick();
    drive(1, 1'b0, 32'h0);
    tick();
    load(1'b1, 32'h24, x);
    tick();
    load(1'b0, 32'h0, 32'h0);
    mem_m[9] = x;
    got = obs(1); vec++;
    if (got !== {3'b110, x}) begin
      miss++; $display("FAIL wf_wait_edge got %h exp %h", got, {3'b110, x});
    end
    tick();
  endtask

  task automatic test_random(input int sel, input int ws, input int n);
    logic [34:0] q[$];
    logic [34:0] e, got;
    logic [31:0] last, a;
    logic        req;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last = NOPV;
    for (int c = 0; c < n; c++) begin
      if (q.size() > 0) e = q.pop_front();
      else e = {3'b100, last};
      last = e[31:0];
      got = obs(sel);
      vec++;
      if (got !== e) begin
        miss++; $display("FAIL rand_dut%0d cyc%0d got %h exp %h", sel * 2, c, got, e);
      end
      req = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        7:       a = $urandom_range(0, 1023) * 4 + $urandom_range(1, 3);
        8:       a = 32'h1000 + $urandom;
        9:       a = ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'hFFC;
        default: a = $urandom_range(0, 1023) * 4;
      endcase
      if (a < 32'h1000 && $urandom_range(0, 1) != 0) a = a & 32'h0000_001F;
      drive(sel, req, a);
      if (req && e[34]) begin
        if ((a % 4) != 0 || a >= 32'h1000) begin
          q.push_back({3'b001, NOPV});
          q.push_back({3'b101, NOPV});
        end else begin
          for (int w = 0; w < ws; w++) q.push_back({3'b000, last});
          q.push_back({3'b110, mem_m[a / 4]});
        end
      end
      tick();
    end
    drive(sel, 1'b0, 32'h0);
  endtask

  initial begin
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);
    load(1'b0, 32'h0, 32'h0);
    test_reset();
    preload();
    test_back_to_back();
    test_wait();
    test_error();
    test_reset_mid();
    test_write_first();
    test_random(0, 0, 300);
    test_random(1, 2, 300);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
